// File: rtl/mul_share_arbiter_if.sv
// Handshake and datapath bundle between the requesters, the shared multiplier
// and the response consumer. The arbiter connects through the slave modport.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN0_WIDTH = 31,
    parameter int DIN1_WIDTH = 63,
    parameter int DOUT_WIDTH = 94
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic                          mul_ce;
    logic [DIN0_WIDTH-1:0]         mul_din0;
    logic [DIN1_WIDTH-1:0]         mul_din1;
    logic [DOUT_WIDTH-1:0]         mul_dout;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DOUT_WIDTH-1:0]         rsp_data;
    logic [ID_WIDTH+1:0]           inflight;

    modport slave (
        input  req_valid, req_din0, req_din1, mul_dout, rsp_ready,
        output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, inflight
    );

    modport master (
        output req_valid, req_din0, req_din1, mul_dout, rsp_ready,
        input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, inflight
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters; a
// tag pipeline running in lock-step with the multiplier carries requester IDs.
module mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DIN0_WIDTH  = 31,
    parameter int DIN1_WIDTH  = 63,
    parameter int DOUT_WIDTH  = 94,
    parameter int MUL_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    mul_share_arbiter_if.slave bus
);
    if (DOUT_WIDTH != DIN0_WIDTH + DIN1_WIDTH) begin : g_bad_dout
        $error("DOUT_WIDTH must equal DIN0_WIDTH + DIN1_WIDTH");
    end
    if (ID_WIDTH != ((NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ))) begin : g_bad_id
        $error("ID_WIDTH must equal ceil(log2(NUM_REQ))");
    end

    logic [MUL_LATENCY-1:0]               tag_vld_q, tag_vld_d;
    logic [MUL_LATENCY-1:0][ID_WIDTH-1:0] tag_id_q, tag_id_d;
    logic [ID_WIDTH-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH+1:0]                  inflight_q, inflight_d;
    logic                                 mul_ce;
    logic                                 grant_any;
    logic [ID_WIDTH-1:0]                  grant_id;

    assign bus.rsp_valid = tag_vld_q[MUL_LATENCY-1];
    assign bus.rsp_id    = tag_id_q[MUL_LATENCY-1];
    assign bus.rsp_data  = bus.mul_dout;
    assign bus.inflight  = inflight_q;
    // A result sitting unaccepted at the tail freezes multiplier and tags together.
    assign mul_ce        = !(tag_vld_q[MUL_LATENCY-1] && !bus.rsp_ready);
    assign bus.mul_ce    = mul_ce;

    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        idx       = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        if (!mul_ce || reset) begin
            grant_any = 1'b0;
            grant_id  = '0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.mul_din0  = '0;
        bus.mul_din1  = '0;
        if (grant_any) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.mul_din0 = bus.req_din0[grant_id*DIN0_WIDTH +: DIN0_WIDTH];
            bus.mul_din1 = bus.req_din1[grant_id*DIN1_WIDTH +: DIN1_WIDTH];
        end
    end

    always_comb begin
        tag_vld_d  = tag_vld_q;
        tag_id_d   = tag_id_q;
        rr_ptr_d   = rr_ptr_q;
        inflight_d = '0;
        if (mul_ce) begin
            tag_vld_d = {tag_vld_q[MUL_LATENCY-2:0], grant_any};
            tag_id_d  = {tag_id_q[MUL_LATENCY-2:0], grant_id};
        end
        if (grant_any) begin
            rr_ptr_d = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        for (int s = 0; s < MUL_LATENCY; s++) begin
            inflight_d = inflight_d + (ID_WIDTH+2)'(tag_vld_d[s]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: a 4-stage multiplier model, a queue-based
// reference of in-order responses, a vector table and directed corner cases.
module tb_mul_share_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int W0 = 31;
    localparam int W1 = 63;
    localparam int WO = 94;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0] rv = '0;
    logic          rr = 1'b1;
    logic [W0-1:0] a_op [NR];
    logic [W1-1:0] b_op [NR];
    logic [WO-1:0] mp [LAT];

    int n_chk = 0;
    int n_fail = 0;

    mul_share_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .DIN0_WIDTH(W0),
                           .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)) bus ();

    mul_share_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1),
                        .DOUT_WIDTH(WO), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    assign bus.req_valid = rv;
    assign bus.rsp_ready = rr;
    assign bus.mul_dout  = mp[LAT-1];

    always_comb begin
        bus.req_din0 = '0;
        bus.req_din1 = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_din0[i*W0 +: W0] = a_op[i];
            bus.req_din1[i*W1 +: W1] = b_op[i];
        end
    end

    // Multiplier: LAT ce-gated register stages, no reset.
    always_ff @(posedge clk) begin
        if (bus.mul_ce) begin
            mp[0] <= {{W1{1'b0}}, bus.mul_din0} * {{W0{1'b0}}, bus.mul_din1};
            for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv = '0;
        rr = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference: ordered list of accepted operations, each aging one step per
    // unstalled cycle; the oldest one is presented once it has aged LAT steps.
    typedef struct {
        logic [IW-1:0] id;
        logic [WO-1:0] prod;
        int            age;
    } ent_t;
    ent_t mq [$];
    int   mptr = 0;
    logic m_ev, m_st, m_gf;
    int   m_gid;
    ent_t m_e;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_inflight", bus.inflight, 0);
            chk("rst_mul_ce", bus.mul_ce, 1);
            chk("rst_mul_din", {bus.mul_din0, bus.mul_din1}, 0);
            mq.delete();
            mptr = 0;
        end else begin
            m_ev = (mq.size() != 0) && (mq[0].age == LAT);
            m_st = m_ev && !rr;
            chk("rsp_valid", bus.rsp_valid, m_ev);
            if (m_ev) begin
                chk("rsp_id", bus.rsp_id, mq[0].id);
                chk("rsp_data", bus.rsp_data, mq[0].prod);
            end
            chk("mul_ce", bus.mul_ce, !m_st);
            chk("inflight", bus.inflight, mq.size());
            m_gf = 1'b0;
            m_gid = 0;
            if (!m_st) begin
                for (int k = 0; k < NR; k++) begin
                    if (!m_gf && rv[(mptr + k) % NR]) begin
                        m_gf = 1'b1;
                        m_gid = (mptr + k) % NR;
                    end
                end
            end
            chk("req_ready", bus.req_ready, m_gf ? (128'd1 << m_gid) : 128'd0);
            chk("mul_din0", bus.mul_din0, m_gf ? a_op[m_gid] : '0);
            chk("mul_din1", bus.mul_din1, m_gf ? b_op[m_gid] : '0);
            if (m_ev && rr) void'(mq.pop_front());
            if (!m_st) begin
                for (int i = 0; i < mq.size(); i++) begin
                    m_e = mq[i];
                    m_e.age = m_e.age + 1;
                    mq[i] = m_e;
                end
            end
            if (m_gf) begin
                m_e.id = IW'(m_gid);
                m_e.prod = {{W1{1'b0}}, a_op[m_gid]} * {{W0{1'b0}}, b_op[m_gid]};
                m_e.age = 1;
                mq.push_back(m_e);
                mptr = (m_gid + 1) % NR;
            end
        end
    end

    typedef struct {
        logic [NR-1:0] rv;
        logic [NR-1:0] exp_rdy;
        logic [W0-1:0] exp_a;
    } vec_t;
    vec_t tbl [11];

    logic [WO-1:0] emax;

    initial begin
        for (int i = 0; i < NR; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        tbl[0]  = '{4'b0000, 4'b0000, 31'd0};
        tbl[1]  = '{4'b0100, 4'b0100, 31'd12};
        tbl[2]  = '{4'b1111, 4'b1000, 31'd13};
        tbl[3]  = '{4'b1111, 4'b0001, 31'd10};
        tbl[4]  = '{4'b0001, 4'b0001, 31'd10};
        tbl[5]  = '{4'b0011, 4'b0010, 31'd11};
        tbl[6]  = '{4'b0011, 4'b0001, 31'd10};
        tbl[7]  = '{4'b1100, 4'b0100, 31'd12};
        tbl[8]  = '{4'b1100, 4'b1000, 31'd13};
        tbl[9]  = '{4'b0000, 4'b0000, 31'd0};
        tbl[10] = '{4'b1010, 4'b0010, 31'd11};

        // Arbitration vectors, never stalled.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_op[i] = W0'(10 + i);
            b_op[i] = W1'(i + 1);
        end
        for (int v = 0; v < 11; v++) begin
            rv = tbl[v].rv;
            @(negedge clk);
            chk("tbl_grant", bus.req_ready, tbl[v].exp_rdy);
            chk("tbl_din0", bus.mul_din0, tbl[v].exp_a);
            tick();
        end
        rv = '0;
        repeat (6) tick();

        // Single request, latency and inflight profile.
        do_reset();
        a_op[2] = 31'd3;
        b_op[2] = 63'd5;
        rv = 4'b0100;
        @(negedge clk);
        chk("sr_grant", bus.req_ready, 4'b0100);
        for (int c = 1; c <= 5; c++) begin
            tick();
            rv = '0;
            @(negedge clk);
            chk("sr_valid", bus.rsp_valid, c == 4);
            chk("sr_inflight", bus.inflight, (c <= 4) ? 1 : 0);
            if (c == 4) begin
                chk("sr_id", bus.rsp_id, 2);
                chk("sr_data", bus.rsp_data, 15);
            end
        end
        tick();

        // Full contention: strict rotation, responses in grant order.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_op[i] = W0'(i + 1);
            b_op[i] = 63'd10;
        end
        rv = 4'hF;
        for (int c = 0; c < 14; c++) begin
            if (c == 8) rv = '0;
            @(negedge clk);
            if (c < 8) chk("fc_grant", bus.req_ready, 4'b0001 << (c % 4));
            if (c >= 4 && c < 12) begin
                chk("fc_valid", bus.rsp_valid, 1);
                chk("fc_id", bus.rsp_id, (c - 4) % 4);
                chk("fc_data", bus.rsp_data, ((c - 4) % 4 + 1) * 10);
            end
            tick();
        end

        // Max operands, no sign extension anywhere.
        do_reset();
        emax = -(94'd1 << 63) - (94'd1 << 31) + 94'd1;
        a_op[0] = 31'h7FFF_FFFF;
        b_op[0] = '1;
        rv = 4'b0001;
        tick();
        rv = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("max_valid", bus.rsp_valid, 1);
        chk("max_data", bus.rsp_data, emax);
        tick();

        // Backpressure: 5 stalled cycles at the first result.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_op[i] = W0'(i + 2);
            b_op[i] = 63'd7;
        end
        for (int c = 0; c < 12; c++) begin
            rv = (c < 3) ? (4'b0001 << c) : ((c >= 4 && c <= 8) ? 4'b1000 : 4'b0000);
            rr = !(c >= 4 && c <= 8);
            @(negedge clk);
            if (c >= 4 && c <= 8) begin
                chk("bp_ce", bus.mul_ce, 0);
                chk("bp_ready", bus.req_ready, 0);
                chk("bp_valid", bus.rsp_valid, 1);
                chk("bp_hold_id", bus.rsp_id, 0);
                chk("bp_hold_data", bus.rsp_data, 14);
            end
            if (c >= 9) begin
                chk("bp_valid_out", bus.rsp_valid, 1);
                chk("bp_id_out", bus.rsp_id, c - 9);
                chk("bp_data_out", bus.rsp_data, (c - 9 + 2) * 7);
            end
            tick();
        end
        rv = '0;
        rr = 1'b1;
        @(negedge clk);
        chk("bp_no_dup", bus.rsp_valid, 0);
        tick();

        // Bubbles are kept; pointer lands on 2 after each grant to 1.
        do_reset();
        a_op[1] = 31'd9;
        b_op[1] = 63'd4;
        for (int c = 0; c < 8; c++) begin
            rv = (c == 0 || c == 2) ? 4'b0010 : ((c == 7) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            if (c == 0 || c == 2) chk("bub_grant", bus.req_ready, 4'b0010);
            if (c == 7) chk("bub_ptr", bus.req_ready, 4'b0100);
            if (c >= 4 && c <= 6) chk("bub_valid", bus.rsp_valid, c != 5);
            if (c == 4 || c == 6) chk("bub_data", bus.rsp_data, 36);
            tick();
        end
        rv = '0;
        repeat (6) tick();

        // Reset with two operations in flight.
        do_reset();
        rv = 4'b0001;
        tick();
        rv = 4'b0010;
        tick();
        reset = 1'b1;
        rv = '0;
        @(negedge clk);
        chk("mr_valid", bus.rsp_valid, 0);
        chk("mr_inflight", bus.inflight, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mr_quiet", bus.rsp_valid, 0);
            tick();
        end
        rv = 4'hF;
        @(negedge clk);
        chk("mr_grant0", bus.req_ready, 4'b0001);
        tick();
        rv = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("mr_lat", bus.rsp_valid, 1);
        chk("mr_id", bus.rsp_id, 0);
        tick();

        // Random traffic against the reference queue.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                a_op[i] = W0'($urandom);
                b_op[i] = W1'({$urandom, $urandom});
            end
            rv = NR'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        rv = '0;
        rr = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("drain_inflight", bus.inflight, 0);
        chk("drain_valid", bus.rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
